// File: rtl/rx_word_sync_ctrl.sv
// Word-alignment and sync controller for the 8b/10b receive path.
// Hunts for a comma at a fixed bit position, slips the deserializer until found, and tracks loss of sync.
module rx_word_sync_ctrl #(
    parameter int SEARCH_WIN   = 16,
    parameter int SLIP_HOLDOFF = 4,
    parameter int COMMA_LOCK   = 3,
    parameter int GOOD_CNT     = 4,
    parameter int ERR_LOSS     = 4
) (
    input  logic       BitCLK_10,
    input  logic       Reset,
    input  logic [9:0] RxParallel_10,
    input  logic       decode_error,
    input  logic       disparity_error,
    output logic       BitSlip,
    output logic       SyncStatus,
    output logic       CommaDet,
    output logic [3:0] SlipCount,
    output logic [7:0] SyncLossCount
);

    localparam int WIN_W  = $clog2(SEARCH_WIN + 1);
    localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);
    localparam int LOCK_W = $clog2(COMMA_LOCK + 1);
    localparam int GOOD_W = $clog2(GOOD_CNT + 1);
    localparam int ERR_W  = $clog2(ERR_LOSS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_HOLDOFF - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(COMMA_LOCK - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_CNT - 1);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LOSS - 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SLIP = 2'd1,
        CDET = 2'd2,
        SYNC = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic                comma_det_q, comma_det_d;
    logic                bit_slip_q, bit_slip_d;
    logic                sync_q, sync_d;
    logic [3:0]          slip_cnt_q, slip_cnt_d;
    logic [7:0]          loss_cnt_q, loss_cnt_d;

    logic                word_err;
    logic                unused_upper_bits;

    // Only the K28 comma bits a..f plus i are inspected; the upper bits never affect alignment.
    assign comma_det_d       = (RxParallel_10[6:0] == 7'b1111100) || (RxParallel_10[6:0] == 7'b0000011);
    assign unused_upper_bits = ^RxParallel_10[9:7];
    assign word_err          = decode_error | disparity_error;

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        comma_cnt_d = comma_cnt_q;
        good_cnt_d  = good_cnt_q;
        err_cnt_d   = err_cnt_q;
        bit_slip_d  = 1'b0;
        slip_cnt_d  = slip_cnt_q;
        loss_cnt_d  = loss_cnt_q;

        case (state_q)
            HUNT: begin
                if (comma_det_q && !word_err) begin
                    state_d     = CDET;
                    comma_cnt_d = LOCK_W'(1);
                    win_cnt_d   = '0;
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d    = SLIP;
                    bit_slip_d = 1'b1;
                    slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                    win_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end

            SLIP: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = HUNT;
                    hold_cnt_d = '0;
                    win_cnt_d  = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end

            // win_cnt here measures words since the last comma, so a stalled candidate gives up without slipping.
            CDET: begin
                if (word_err) begin
                    state_d     = HUNT;
                    win_cnt_d   = '0;
                    comma_cnt_d = '0;
                end else if (comma_det_q) begin
                    win_cnt_d = '0;
                    if (comma_cnt_q == LOCK_LAST) begin
                        state_d     = SYNC;
                        comma_cnt_d = '0;
                        err_cnt_d   = '0;
                        good_cnt_d  = '0;
                    end else begin
                        comma_cnt_d = comma_cnt_q + LOCK_W'(1);
                    end
                end else if (win_cnt_q == WIN_LAST) begin
                    state_d     = HUNT;
                    win_cnt_d   = '0;
                    comma_cnt_d = '0;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end

            SYNC: begin
                if (word_err) begin
                    good_cnt_d = '0;
                    if (err_cnt_q == ERR_LAST) begin
                        state_d   = HUNT;
                        err_cnt_d = '0;
                        win_cnt_d = '0;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_d = loss_cnt_q + 8'd1;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else if (good_cnt_q == GOOD_LAST) begin
                    good_cnt_d = '0;
                    if (err_cnt_q != '0) begin
                        err_cnt_d = err_cnt_q - ERR_W'(1);
                    end
                end else begin
                    good_cnt_d = good_cnt_q + GOOD_W'(1);
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase

        sync_d = (state_d == SYNC);
    end

    always_ff @(posedge BitCLK_10 or negedge Reset) begin
        if (!Reset) begin
            state_q     <= HUNT;
            win_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            comma_cnt_q <= '0;
            good_cnt_q  <= '0;
            err_cnt_q   <= '0;
            comma_det_q <= 1'b0;
            bit_slip_q  <= 1'b0;
            sync_q      <= 1'b0;
            slip_cnt_q  <= '0;
            loss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_cnt_q   <= win_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            good_cnt_q  <= good_cnt_d;
            err_cnt_q   <= err_cnt_d;
            comma_det_q <= comma_det_d;
            bit_slip_q  <= bit_slip_d;
            sync_q      <= sync_d;
            slip_cnt_q  <= slip_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
        end
    end

    assign BitSlip       = bit_slip_q;
    assign SyncStatus    = sync_q;
    assign CommaDet      = comma_det_q;
    assign SlipCount     = slip_cnt_q;
    assign SyncLossCount = loss_cnt_q;

endmodule

// File: tb/tb_rx_word_sync_ctrl.sv
// Bench for rx_word_sync_ctrl: a serial K28.5 stream behind a bit-slipping deserializer model,
// directed scenarios plus random traffic, scored against a word-level reference model.
module tb_rx_word_sync_ctrl;

    localparam int SEARCH_WIN   = 16;
    localparam int SLIP_HOLDOFF = 4;
    localparam int COMMA_LOCK   = 3;
    localparam int GOOD_CNT     = 4;
    localparam int ERR_LOSS     = 4;

    logic       BitCLK_10       = 1'b0;
    logic       Reset           = 1'b0;
    logic [9:0] RxParallel_10   = '0;
    logic       decode_error    = 1'b0;
    logic       disparity_error = 1'b0;
    logic       BitSlip;
    logic       SyncStatus;
    logic       CommaDet;
    logic [3:0] SlipCount;
    logic [7:0] SyncLossCount;

    rx_word_sync_ctrl #(
        .SEARCH_WIN  (SEARCH_WIN),
        .SLIP_HOLDOFF(SLIP_HOLDOFF),
        .COMMA_LOCK  (COMMA_LOCK),
        .GOOD_CNT    (GOOD_CNT),
        .ERR_LOSS    (ERR_LOSS)
    ) dut (
        .BitCLK_10      (BitCLK_10),
        .Reset          (Reset),
        .RxParallel_10  (RxParallel_10),
        .decode_error   (decode_error),
        .disparity_error(disparity_error),
        .BitSlip        (BitSlip),
        .SyncStatus     (SyncStatus),
        .CommaDet       (CommaDet),
        .SlipCount      (SlipCount),
        .SyncLossCount  (SyncLossCount)
    );

    always #5 BitCLK_10 = ~BitCLK_10;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [14:0] expQ[$];

    // Serial bit position of the deserializer window in the transmitted stream.
    int          streamPos = 0;
    logic [9:0]  drvWord   = '0;
    bit          drvErr    = 1'b0;

    // Reference model: the link status is derived from run counters rather than a state variable.
    bit mCommaDet, mBitSlip, mLocked;
    int mSlipLeft, mCommaRun, mWordsSince, mErrs, mGoods, mSlips, mLosses;

    function automatic logic [9:0] streamWord(input int p);
        logic [19:0] pat;
        logic [9:0]  w;
        pat = 20'b1010000011_0101111100;
        for (int i = 0; i < 10; i++) begin
            w[i] = pat[(p + i) % 20];
        end
        return w;
    endfunction

    function automatic bit isComma(input logic [9:0] w);
        logic [6:0] low;
        low = w[6:0];
        return (low == 7'b1111100) || (low == 7'b0000011);
    endfunction

    task automatic modelReset();
        mCommaDet   = 1'b0;
        mBitSlip    = 1'b0;
        mLocked     = 1'b0;
        mSlipLeft   = 0;
        mCommaRun   = 0;
        mWordsSince = 0;
        mErrs       = 0;
        mGoods      = 0;
        mSlips      = 0;
        mLosses     = 0;
    endtask

    task automatic modelStep(input logic [9:0] w, input bit e);
        mBitSlip = 1'b0;
        if (mSlipLeft > 0) begin
            mSlipLeft--;
            if (mSlipLeft == 0) mWordsSince = 0;
        end else if (mLocked) begin
            if (e) begin
                mErrs++;
                mGoods = 0;
                if (mErrs == ERR_LOSS) begin
                    mLocked     = 1'b0;
                    mErrs       = 0;
                    mWordsSince = 0;
                    mLosses     = (mLosses < 255) ? mLosses + 1 : 255;
                end
            end else begin
                mGoods++;
                if (mGoods == GOOD_CNT) begin
                    mGoods = 0;
                    if (mErrs > 0) mErrs--;
                end
            end
        end else if (mCommaRun > 0) begin
            if (e) begin
                mCommaRun   = 0;
                mWordsSince = 0;
            end else if (mCommaDet) begin
                mCommaRun++;
                mWordsSince = 0;
                if (mCommaRun == COMMA_LOCK) begin
                    mLocked   = 1'b1;
                    mCommaRun = 0;
                    mErrs     = 0;
                    mGoods    = 0;
                end
            end else if (mWordsSince == SEARCH_WIN - 1) begin
                mCommaRun   = 0;
                mWordsSince = 0;
            end else begin
                mWordsSince++;
            end
        end else begin
            if (mCommaDet && !e) begin
                mCommaRun   = 1;
                mWordsSince = 0;
            end else if (mWordsSince == SEARCH_WIN - 1) begin
                mSlipLeft   = SLIP_HOLDOFF;
                mBitSlip    = 1'b1;
                mSlips      = (mSlips + 1) % 10;
                mWordsSince = 0;
            end else begin
                mWordsSince++;
            end
        end
        mCommaDet = isComma(w);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic driveWord(input logic [9:0] w, input bit dErr, input bit pErr);
        drvWord         = w;
        drvErr          = dErr | pErr;
        RxParallel_10   = w;
        decode_error    = dErr;
        disparity_error = pErr;
    endtask

    // One word clock: score the edge, let the deserializer react to a slip, then present the next word.
    task automatic applyStimulus(input bit randomWord, input bit dErr, input bit pErr);
        logic [9:0] w;
        @(posedge BitCLK_10);
        modelStep(drvWord, drvErr);
        expQ.push_back({mBitSlip, mLocked, mCommaDet, 4'(mSlips), 8'(mLosses)});
        if (mBitSlip) streamPos++;
        #1;
        w = randomWord ? 10'($urandom_range(0, 1023)) : streamWord(streamPos);
        streamPos += 10;
        driveWord(w, dErr, pErr);
    endtask

    task automatic runClean(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic runErrors(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, i[0], ~i[0]);
    endtask

    task automatic doReset();
        @(negedge BitCLK_10);
        #1 Reset = 1'b0;
        #1 checkOutput("async_reset_outputs", {17'd0, BitSlip, SyncStatus, CommaDet, SlipCount, SyncLossCount}, 32'd0);
        expQ.delete();
        modelReset();
        driveWord(streamWord(streamPos), 1'b0, 1'b0);
        streamPos += 10;
        repeat (2) @(negedge BitCLK_10);
        Reset = 1'b1;
    endtask

    // Monitor: every word clock the DUT presents a full output set, compared against the oldest prediction.
    initial begin
        logic [14:0] expV, actV;
        forever begin
            @(negedge BitCLK_10);
            if (expQ.size() > 0) begin
                expV = expQ.pop_front();
                actV = {BitSlip, SyncStatus, CommaDet, SlipCount, SyncLossCount};
                nCompared++;
                if (actV !== expV) begin
                    nMismatched++;
                    $display("[TB] FAIL outputs @%0t: got slip=%0b sync=%0b comma=%0b slipcnt=%0d loss=%0d, expected slip=%0b sync=%0b comma=%0b slipcnt=%0d loss=%0d",
                             $time, actV[14], actV[13], actV[12], actV[11:8], actV[7:0],
                             expV[14], expV[13], expV[12], expV[11:8], expV[7:0]);
                end
            end
        end
    end

    initial begin
        modelReset();

        $display("[TB] aligned stream lock");
        streamPos = 0;
        doReset();
        runClean(12);
        @(negedge BitCLK_10);
        checkOutput("aligned_sync", 32'(SyncStatus), 32'd1);
        checkOutput("aligned_slipcount", 32'(SlipCount), 32'd0);

        $display("[TB] misaligned stream needing three slips");
        streamPos = 7;
        doReset();
        runClean(90);
        @(negedge BitCLK_10);
        checkOutput("slip3_slipcount", 32'(SlipCount), 32'd3);
        checkOutput("slip3_sync", 32'(SyncStatus), 32'd1);

        $display("[TB] four back-to-back errors in sync");
        runErrors(4);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge BitCLK_10);
        checkOutput("loss_sync_dropped", 32'(SyncStatus), 32'd0);
        checkOutput("loss_count_1", 32'(SyncLossCount), 32'd1);
        runClean(6);
        @(negedge BitCLK_10);
        checkOutput("relock_after_loss", 32'(SyncStatus), 32'd1);

        $display("[TB] isolated errors retired by good words");
        for (int r = 0; r < 10; r++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            runClean(4);
        end
        runErrors(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge BitCLK_10);
        checkOutput("err_cnt_retired_sync", 32'(SyncStatus), 32'd1);
        checkOutput("err_cnt_retired_loss", 32'(SyncLossCount), 32'd1);
        runClean(12);

        $display("[TB] error on a comma during candidate lock");
        runErrors(4);
        runClean(2);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        @(negedge BitCLK_10);
        checkOutput("cdet_err_no_sync", 32'(SyncStatus), 32'd0);
        runClean(6);
        @(negedge BitCLK_10);
        checkOutput("cdet_relock_sync", 32'(SyncStatus), 32'd1);
        checkOutput("cdet_relock_loss", 32'(SyncLossCount), 32'd2);

        $display("[TB] reset during slip and during sync");
        streamPos = 3;
        doReset();
        runClean(16);
        doReset();
        runClean(140);
        @(negedge BitCLK_10);
        checkOutput("post_slip_reset_slipcount", 32'(SlipCount), 32'd6);
        checkOutput("post_slip_reset_sync", 32'(SyncStatus), 32'd1);
        doReset();
        runClean(12);
        @(negedge BitCLK_10);
        checkOutput("post_sync_reset_sync", 32'(SyncStatus), 32'd1);
        checkOutput("post_sync_reset_loss", 32'(SyncLossCount), 32'd0);

        $display("[TB] loss counter saturation");
        for (int r = 0; r < 260; r++) begin
            runErrors(4);
            runClean(6);
        end
        @(negedge BitCLK_10);
        checkOutput("loss_saturated", 32'(SyncLossCount), 32'd255);

        $display("[TB] random traffic");
        streamPos = $urandom_range(0, 99);
        doReset();
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        @(negedge BitCLK_10);
        @(negedge BitCLK_10);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
